// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, register map and parity helper for uart_tx_buffered
package uart_pkg;

  typedef enum int {
    PARITY_NONE = 0,
    PARITY_EVEN = 1,
    PARITY_ODD  = 2
  } parity_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    TX_IDLE   = ST_IDLE,
    TX_START  = ST_START,
    TX_DATA   = ST_DATA,
    TX_PARITY = ST_PARITY,
    TX_STOP   = ST_STOP
  } tx_state_t;

  localparam logic [1:0] ADR_DATA    = 2'd0;
  localparam logic [1:0] ADR_STATUS  = 2'd1;
  localparam logic [1:0] ADR_DIVISOR = 2'd2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_LEVEL_LSB = 8;

  // Data is zero-extended to 9 bits, so the unused upper bits never disturb the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic p;
    case (mode)
      PARITY_EVEN: p = ^data;
      PARITY_ODD:  p = ~(^data);
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serialiser: start, data LSB first, optional parity, stop bits
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DAT_WIDTH = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid,
  input  logic [DAT_WIDTH-1:0] data,
  input  logic [15:0]          period,
  output logic                 pop,
  output logic                 busy,
  output logic                 uart_tx
);

  logic [2:0]           state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [15:0]          period_q, period_d;
  logic [3:0]           bit_q, bit_d;
  logic [DAT_WIDTH-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 last_tick;
  logic                 load;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    period_d  = period_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    load      = 1'b0;
    last_tick = (baud_q == period_q - 16'd1);

    case (state_q)
      ST_IDLE: begin
        if (valid) load = 1'b1;
      end
      ST_START: begin
        if (last_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (last_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DAT_WIDTH - 1)) begin
            bit_d   = 4'd0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (last_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (last_tick) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d = 4'd0;
            // Chain straight into the next frame when more data is waiting.
            if (valid) load = 1'b1;
            else       state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) baud_d = last_tick ? 16'd0 : baud_q + 16'd1;

    // The bit period is captured per frame so a divisor change never lands mid-frame.
    if (load) begin
      state_d  = ST_START;
      baud_d   = 16'd0;
      bit_d    = 4'd0;
      shift_d  = data;
      par_d    = parity_bit(9'(data), PARITY);
      period_d = period;
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      baud_q   <= 16'd0;
      period_q <= 16'd0;
      bit_q    <= 4'd0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  assign pop     = load;
  assign busy    = (state_q != ST_IDLE);
  assign uart_tx = tx_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - Wishbone UART transmitter with byte FIFO and status register
// Optional runtime DIVISOR register at address 2: UART_TX_BUFFERED_RUNTIME_BAUD_EN.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int DAT_WIDTH      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DAT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q, level_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;

  logic        req, data_wr, accept, push, pop;
  logic        fifo_empty, fifo_full, busy;
  logic [15:0] period;
  logic [31:0] status, rd_data;
  logic        unused_dat;

  assign unused_dat = ^dat_i;

  assign req        = cyc_i && stb_i;
  assign data_wr    = we_i && (adr_i == ADR_DATA);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = level_q[AW];
  // A write into a full FIFO waits; it may complete in the very cycle a slot is popped.
  assign accept     = req && !ack_q && !(data_wr && fifo_full && !pop);
  assign push       = accept && data_wr;

`ifdef UART_TX_BUFFERED_RUNTIME_BAUD_EN
  logic [15:0] divisor_q, divisor_d;

  always_comb begin
    divisor_d = divisor_q;
    if (accept && we_i && (adr_i == ADR_DIVISOR))
      divisor_d = (dat_i[15:0] < 16'd2) ? 16'd2 : dat_i[15:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) divisor_q <= 16'(CLOCKS_PER_BIT);
    else       divisor_q <= divisor_d;
  end

  assign period = divisor_q;
`else
  assign period = 16'(CLOCKS_PER_BIT);
`endif

  always_comb begin
    status                            = '0;
    status[STAT_BUSY]                 = busy;
    status[STAT_EMPTY]                = fifo_empty;
    status[STAT_FULL]                 = fifo_full;
    status[STAT_LEVEL_LSB +: 8]       = 8'(level_q);

    case (adr_i)
      ADR_STATUS:  rd_data = status;
`ifdef UART_TX_BUFFERED_RUNTIME_BAUD_EN
      ADR_DIVISOR: rd_data = {16'd0, divisor_q};
`endif
      default:     rd_data = '0;
    endcase

    ack_d = accept;
    dat_d = (accept && !we_i) ? rd_data : '0;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  // When full and popping together, the written slot is the one being read; the read sees the old byte.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= dat_i[DAT_WIDTH-1:0];
  end

  uart_tx_frame #(
    .DAT_WIDTH (DAT_WIDTH),
    .PARITY    (PARITY),
    .STOP_BITS (STOP_BITS)
  ) u_frame (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid   (!fifo_empty),
    .data    (mem_q[rd_ptr_q]),
    .period  (period),
    .pop     (pop),
    .busy    (busy),
    .uart_tx (uart_tx)
  );

  assign ack_o = ack_q;
  assign dat_o = dat_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered (8E1 depth 2 and 7O2 depth 4)
`timescale 1ns/1ps
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [1:0]  adr [2];
  logic [31:0] wdat[2];
  logic [31:0] rdat[2];
  logic        ack [2];
  logic        txl [2];

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLOCKS_PER_BIT(CPB), .DAT_WIDTH(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .dat_i(wdat[0]), .dat_o(rdat[0]), .ack_o(ack[0]), .uart_tx(txl[0])
  );

  uart_tx_buffered #(
    .CLOCKS_PER_BIT(CPB), .DAT_WIDTH(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .dat_i(wdat[1]), .dat_o(rdat[1]), .ack_o(ack[1]), .uart_tx(txl[1])
  );

  int cfg_dw  [2] = '{8, 7};
  int cfg_par [2] = '{1, 2};
  int cfg_stop[2] = '{1, 2};

  bit exp_q [2][$];
  int pend_q[2][$];
  int mdiv  [2] = '{CPB, CPB};

  int n_chk  = 0;
  int n_fail = 0;

  bit a5_bits[11] = '{0, 1,0,1,0,0,1,0,1, 0, 1};
  bit b07_bits[11] = '{0, 1,1,1,0,0,0,0, 0, 1,1};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expand one byte into its per-cycle line levels from the frame rules.
  function automatic void load_frame(input int k);
    int b;
    int ones;
    bit bits[$];
    b    = pend_q[k].pop_front();
    ones = $countones(b);
    bits.push_back(1'b0);
    for (int i = 0; i < cfg_dw[k]; i++) bits.push_back(b[i]);
    if (cfg_par[k] == 1) bits.push_back(ones % 2 == 1);
    if (cfg_par[k] == 2) bits.push_back(ones % 2 == 0);
    for (int i = 0; i < cfg_stop[k]; i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < mdiv[k]; c++) exp_q[k].push_back(bits[i]);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        exp_q[k].delete();
        pend_q[k].delete();
        mdiv[k] = CPB;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit e;
        e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 1'b1;
        check($sformatf("line_%0d", k), txl[k], e);
        if (ack[k] && we[k]) begin
          if (adr[k] == ADR_DATA)
            pend_q[k].push_back(int'(wdat[k]) & ((1 << cfg_dw[k]) - 1));
`ifdef UART_TX_BUFFERED_RUNTIME_BAUD_EN
          else if (adr[k] == ADR_DIVISOR)
            mdiv[k] = (wdat[k][15:0] < 16'd2) ? 2 : int'(wdat[k][15:0]);
`endif
        end
        if (exp_q[k].size() == 0 && pend_q[k].size() > 0) load_frame(k);
      end
    end
  end

  task automatic wb(input int k, input bit w, input logic [1:0] a, input logic [31:0] d,
                    output logic [31:0] rd, output int lat);
    int n;
    @(posedge clk); #1;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d;
    @(negedge clk);
    check("ack_not_same_cycle", ack[k], 1'b0);
    lat = -1;
    rd  = '0;
    n   = 1;
    while (lat < 0 && n <= 300) begin
      @(negedge clk);
      if (ack[k]) begin
        lat = n;
        rd  = rdat[k];
      end
      n++;
    end
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: no ack on dut %0d within 300 cycles", k);
    end
    @(posedge clk); #1;
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    int l;
    wb(k, 1'b1, a, d, r, l);
    check("wr_ack_latency", l, 1);
  endtask

  task automatic rd_chk(input int k, input logic [1:0] a, input logic [31:0] e, input string nm);
    logic [31:0] r;
    int l;
    wb(k, 1'b0, a, 32'd0, r, l);
    check({nm, "_lat"}, l, 1);
    check(nm, r, e);
  endtask

  task automatic line_chk(input int k, input bit bits[11], input string nm);
    for (int j = 0; j <= 44; j++) begin
      @(negedge clk);
      check(nm, txl[k], (j < 44) ? bits[j / 4] : 1'b1);
    end
  endtask

  initial begin
    logic [31:0] r;
    int l;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; adr[k] = 2'd0; wdat[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_tx", txl[k], 1'b1);
      check("reset_ack", ack[k], 1'b0);
      check("reset_dat", rdat[k], 32'd0);
    end
    rst = 1'b0;

    rd_chk(0, ADR_STATUS, 32'h002, "status_reset_a");
    rd_chk(1, ADR_STATUS, 32'h002, "status_reset_b");

    rd_chk(0, ADR_DATA, 32'd0, "read_data_zero");
    wr(0, 2'd3, 32'h55);
    rd_chk(0, 2'd3, 32'd0, "read_unmapped");
    rd_chk(0, ADR_STATUS, 32'h002, "status_after_unmapped_wr");
`ifndef UART_TX_BUFFERED_RUNTIME_BAUD_EN
    wr(0, ADR_DIVISOR, 32'h6);
    rd_chk(0, ADR_DIVISOR, 32'd0, "divisor_unmapped");
`endif

    wr(0, ADR_DATA, 32'hA5);
    line_chk(0, a5_bits, "bits_a5");
    repeat (4) @(posedge clk);

    wr(1, ADR_DATA, 32'h07);
    line_chk(1, b07_bits, "bits_b07");
    wr(1, ADR_DATA, 32'h1FF);
    repeat (60) @(posedge clk);

    wr(0, ADR_DATA, 32'h00);
    wr(0, ADR_DATA, 32'hFF);
    wr(0, ADR_DATA, 32'h3C);
    rd_chk(0, ADR_STATUS, 32'h205, "status_b2b");
    repeat (150) @(posedge clk);
    rd_chk(0, ADR_STATUS, 32'h002, "status_b2b_done");

    wr(0, ADR_DATA, 32'h11);
    wr(0, ADR_DATA, 32'h22);
    wr(0, ADR_DATA, 32'h33);
    rd_chk(0, ADR_STATUS, 32'h205, "status_full");
    wb(0, 1'b1, ADR_DATA, 32'h44, r, l);
    check("stalled_ack_latency", l, 34);
    repeat (150) @(posedge clk);
    rd_chk(0, ADR_STATUS, 32'h002, "status_full_done");

    wr(0, ADR_DATA, 32'h00);
    repeat (8) @(posedge clk);
    #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = ADR_STATUS;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_ack", ack[0], 1'b1);
    check("pre_reset_tx", txl[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_reset_tx", txl[0], 1'b1);
    check("async_reset_ack", ack[0], 1'b0);
    check("async_reset_dat", rdat[0], 32'd0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_chk(0, ADR_STATUS, 32'h002, "status_after_reset");
    repeat (10) @(posedge clk);

`ifdef UART_TX_BUFFERED_RUNTIME_BAUD_EN
    rd_chk(0, ADR_DIVISOR, CPB, "divisor_reset");
    wr(0, ADR_DIVISOR, 32'h1);
    rd_chk(0, ADR_DIVISOR, 32'd2, "divisor_clamp");
    wr(0, ADR_DIVISOR, CPB);
    wr(0, ADR_DATA, 32'h11);
    wr(0, ADR_DATA, 32'h22);
    wr(0, ADR_DIVISOR, 32'h6);
    rd_chk(0, ADR_DIVISOR, 32'd6, "divisor_six");
    repeat (150) @(posedge clk);
`endif

    for (int k = 0; k < 2; k++) begin
      check("drain_exp", exp_q[k].size(), 0);
      check("drain_pend", pend_q[k].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
